// File: rtl/snake_board_renderer_if.sv
// snake_board_renderer_if
//  Groups the renderer's signals apart from the clock and reset:
//  - Pixel timing inputs: pix_ce, h_cnt, v_cnt, video_on, hsync_in, vsync_in.
//  - Game state: game_over.
//  - Board RAM read port: cell_addr (out), cell_data (in).
//  - VGA pins: HSYNC, VSYNC, Red, Green, Blue.
//  modport slave  : the renderer.
//  modport master : the environment, which drives timing, game state and RAM data.
interface snake_board_renderer_if;
  logic        pix_ce;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic        game_over;
  logic [10:0] cell_addr;
  logic [1:0]  cell_data;
  logic        HSYNC;
  logic        VSYNC;
  logic [3:0]  Red;
  logic [3:0]  Green;
  logic [3:0]  Blue;

  modport master (
    output pix_ce, h_cnt, v_cnt, video_on, hsync_in, vsync_in, game_over, cell_data,
    input  cell_addr, HSYNC, VSYNC, Red, Green, Blue
  );

  modport slave (
    input  pix_ce, h_cnt, v_cnt, video_on, hsync_in, vsync_in, game_over, cell_data,
    output cell_addr, HSYNC, VSYNC, Red, Green, Blue
  );
endinterface

// File: rtl/snake_board_renderer.sv
// snake_board_renderer
//  Pixel-colour stage for the snake game's VGA output. A three-stage pipeline
//  (advancing only on pix_ce) turns pixel coordinates into a board RAM address,
//  picks up the cell contents and produces registered 12-bit RGB with the syncs
//  delayed by the same three stages.
//  Ports:
//   clk_100mhz : system clock, rising edge
//   RST        : asynchronous active-high reset
//   bus        : snake_board_renderer_if.slave (timing in, RAM port, VGA pins)
module snake_board_renderer #(
  parameter int CELL_SHIFT = 4,
  parameter int GRID_W     = 40,
  parameter int GRID_H     = 30,
  parameter int BLINK_BIT  = 4
) (
  input  logic                   clk_100mhz,
  input  logic                   RST,
  snake_board_renderer_if.slave  bus
);
  localparam int CW = 10 - CELL_SHIFT;
  localparam logic [CW-1:0]         GRID_W_C = CW'(GRID_W);
  localparam logic [CW-1:0]         GRID_H_C = CW'(GRID_H);
  localparam logic [CELL_SHIFT-1:0] FOOD_LO  = CELL_SHIFT'(2);
  localparam logic [CELL_SHIFT-1:0] FOOD_HI  = CELL_SHIFT'((1 << CELL_SHIFT) - 3);

  // Stage 1
  logic [10:0]           cell_addr_reg;
  logic [CELL_SHIFT-1:0] s1_offx_reg, s1_offy_reg;
  logic                  s1_in_reg, s1_hs_reg, s1_vs_reg;
  logic [4:0]            frame_cnt_reg;
  // Stage 2
  logic [CELL_SHIFT-1:0] s2_offx_reg, s2_offy_reg;
  logic                  s2_in_reg, s2_hs_reg, s2_vs_reg;
  logic                  s2_fresh_reg;
  logic [1:0]            s2_cell_reg;
  // Stage 3
  logic [11:0]           rgb_reg;
  logic                  hs_reg, vs_reg;

  logic [CW-1:0] col, row;
  logic          in_grid;
  logic [10:0]   addr_next;
  logic [1:0]    cell_now;
  logic          food_vis;
  logic [11:0]   rgb_next;

  assign col     = bus.h_cnt[9:CELL_SHIFT];
  assign row     = bus.v_cnt[9:CELL_SHIFT];
  assign in_grid = bus.video_on && (col < GRID_W_C) && (row < GRID_H_C);
  // row*40 as (row<<5)+(row<<3): tied to the 40-cell board width.
  assign addr_next = in_grid ? (11'({row, 5'b0}) + 11'({row, 3'b0}) + 11'(col)) : 11'd0;

  // The RAM returns data one clk after it samples the address, which it first
  // sees one clk after S1 registers it. So the data for the cell now in S2 is
  // only on cell_data during the clk after S2 advanced. If S3 advances on that
  // very clk (pix_ce held high) it takes cell_data directly; otherwise the copy
  // captured on that clk is used.
  assign cell_now = s2_fresh_reg ? bus.cell_data : s2_cell_reg;

  assign food_vis = (s2_offx_reg >= FOOD_LO) && (s2_offx_reg <= FOOD_HI) &&
                    (s2_offy_reg >= FOOD_LO) && (s2_offy_reg <= FOOD_HI) &&
                    !frame_cnt_reg[BLINK_BIT];

  always_comb begin
    rgb_next = 12'h000;
    if (s2_in_reg) begin
      case (cell_now)
        2'b00: if (s2_offx_reg == '0 || s2_offy_reg == '0) rgb_next = 12'h222;
        2'b01: rgb_next = bus.game_over ? 12'hF00 : 12'h0F0;
        2'b10: rgb_next = bus.game_over ? 12'hF80 : 12'hFF0;
        default: if (food_vis) rgb_next = 12'hF0F;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz or posedge RST) begin
    if (RST) begin
      cell_addr_reg <= '0;
      s1_offx_reg   <= '0;
      s1_offy_reg   <= '0;
      s1_in_reg     <= 1'b0;
      s1_hs_reg     <= 1'b1;
      s1_vs_reg     <= 1'b1;
      frame_cnt_reg <= '0;
      s2_offx_reg   <= '0;
      s2_offy_reg   <= '0;
      s2_in_reg     <= 1'b0;
      s2_hs_reg     <= 1'b1;
      s2_vs_reg     <= 1'b1;
      s2_fresh_reg  <= 1'b0;
      s2_cell_reg   <= '0;
      rgb_reg       <= '0;
      hs_reg        <= 1'b1;
      vs_reg        <= 1'b1;
    end else begin
      s2_fresh_reg <= bus.pix_ce;
      if (s2_fresh_reg) s2_cell_reg <= bus.cell_data;
      if (bus.pix_ce) begin
        cell_addr_reg <= addr_next;
        s1_offx_reg   <= bus.h_cnt[CELL_SHIFT-1:0];
        s1_offy_reg   <= bus.v_cnt[CELL_SHIFT-1:0];
        s1_in_reg     <= in_grid;
        s1_hs_reg     <= bus.hsync_in;
        s1_vs_reg     <= bus.vsync_in;
        // Rising vsync_in, seen against the vsync held in S1, counts a frame.
        if (bus.vsync_in && !s1_vs_reg) frame_cnt_reg <= frame_cnt_reg + 5'd1;

        s2_offx_reg <= s1_offx_reg;
        s2_offy_reg <= s1_offy_reg;
        s2_in_reg   <= s1_in_reg;
        s2_hs_reg   <= s1_hs_reg;
        s2_vs_reg   <= s1_vs_reg;

        rgb_reg <= rgb_next;
        hs_reg  <= s2_hs_reg;
        vs_reg  <= s2_vs_reg;
      end
    end
  end

  assign bus.cell_addr = cell_addr_reg;
  assign bus.Red       = rgb_reg[11:8];
  assign bus.Green     = rgb_reg[7:4];
  assign bus.Blue      = rgb_reg[3:0];
  assign bus.HSYNC     = hs_reg;
  assign bus.VSYNC     = vs_reg;
endmodule

// File: tb/tb_snake_board_renderer.sv
module tb_snake_board_renderer;
  logic clk_100mhz = 1'b0;
  logic RST = 1'b1;
  int   cmp_cnt  = 0;
  int   mism_cnt = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  snake_board_renderer_if bus();

  snake_board_renderer dut (
    .clk_100mhz (clk_100mhz),
    .RST        (RST),
    .bus        (bus)
  );

  // Board RAM model: registered read, one clk latency.
  logic [1:0] mem [0:2047];
  always @(posedge clk_100mhz) bus.cell_data <= mem[bus.cell_addr];

  logic [11:0] rgb;
  assign rgb = {bus.Red, bus.Green, bus.Blue};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mism_cnt++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int h, input int v, input logic von, input logic hs, input logic vs);
    bus.h_cnt    = 10'(h);
    bus.v_cnt    = 10'(v);
    bus.video_on = von;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
  endtask

  // One pixel: a single-clk pix_ce pulse followed by three idle clks.
  task automatic px(input int h, input int v, input logic von, input logic hs, input logic vs);
    drive(h, v, von, hs, vs);
    bus.pix_ce = 1'b1;
    @(negedge clk_100mhz);
    bus.pix_ce = 1'b0;
    repeat (3) @(negedge clk_100mhz);
    $display("pixel h=%0d v=%0d von=%0b hs=%0b vs=%0b -> addr=%0d rgb=%h hsync=%0b vsync=%0b",
             h, v, von, hs, vs, bus.cell_addr, rgb, bus.HSYNC, bus.VSYNC);
  endtask

  task automatic filler();
    px(0, 0, 1'b0, 1'b1, 1'b1);
  endtask

  int          sh_h   [5] = '{100, 117, 128, 152, 133};
  int          sh_v   [5] = '{50, 53, 53, 56, 53};
  logic [11:0] sh_rgb [5] = '{12'h0F0, 12'hFF0, 12'h222, 12'hF0F, 12'h000};
  logic        sh_hs  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 2'b00;
    mem[0]    = 2'b01;   // would show green if out-of-grid pixels leaked through
    mem[40]   = 2'b01;
    mem[126]  = 2'b01;   // body  (col 6, row 3)
    mem[127]  = 2'b10;   // head  (col 7, row 3)
    mem[128]  = 2'b00;   // empty (col 8, row 3)
    mem[129]  = 2'b11;   // food  (col 9, row 3)
    mem[1199] = 2'b01;   // body  (col 39, row 29)
    bus.pix_ce    = 1'b0;
    bus.game_over = 1'b0;
    drive(0, 0, 1'b0, 1'b1, 1'b1);

    // Reset state
    repeat (2) @(negedge clk_100mhz);
    check("rst_rgb",   16'(rgb), 16'h000);
    check("rst_hsync", 16'(bus.HSYNC), 16'h1);
    check("rst_vsync", 16'(bus.VSYNC), 16'h1);
    check("rst_addr",  16'(bus.cell_addr), 16'd0);
    RST = 1'b0;
    @(negedge clk_100mhz);

    // Address and body colour
    px(100, 50, 1'b1, 1'b1, 1'b1);
    check("addr_126", 16'(bus.cell_addr), 16'd126);
    filler(); filler();
    check("body_0F0", 16'(rgb), 16'h0F0);

    px(639, 479, 1'b1, 1'b1, 1'b1);
    check("addr_1199", 16'(bus.cell_addr), 16'd1199);
    filler(); filler();
    check("corner_body", 16'(rgb), 16'h0F0);

    px(117, 53, 1'b1, 1'b1, 1'b1);
    filler(); filler();
    check("head_FF0", 16'(rgb), 16'hFF0);

    px(128, 53, 1'b1, 1'b1, 1'b1);
    filler(); filler();
    check("grid_line", 16'(rgb), 16'h222);

    px(133, 53, 1'b1, 1'b1, 1'b1);
    filler(); filler();
    check("empty_000", 16'(rgb), 16'h000);

    // game_over recolours snake cells
    bus.game_over = 1'b1;
    px(100, 50, 1'b1, 1'b1, 1'b1);
    filler(); filler();
    check("gover_body", 16'(rgb), 16'hF00);
    px(117, 53, 1'b1, 1'b1, 1'b1);
    filler(); filler();
    check("gover_head", 16'(rgb), 16'hF80);
    bus.game_over = 1'b0;

    // Food, frame 0
    px(152, 56, 1'b1, 1'b1, 1'b1);
    check("addr_food", 16'(bus.cell_addr), 16'd129);
    filler(); filler();
    check("food_vis", 16'(rgb), 16'hF0F);
    px(145, 56, 1'b1, 1'b1, 1'b1);
    filler(); filler();
    check("food_edge", 16'(rgb), 16'h000);

    // Blanking over a body cell, and hsync pulse delay
    px(100, 50, 1'b0, 1'b0, 1'b1);
    check("blank_addr", 16'(bus.cell_addr), 16'd0);
    check("hs_d1", 16'(bus.HSYNC), 16'h1);
    filler();
    check("hs_d2", 16'(bus.HSYNC), 16'h1);
    filler();
    check("blank_rgb", 16'(rgb), 16'h000);
    check("hs_d3", 16'(bus.HSYNC), 16'h0);
    filler();
    check("hs_d4", 16'(bus.HSYNC), 16'h1);

    // video_on with h_cnt beyond the board
    px(640, 0, 1'b1, 1'b1, 1'b1);
    check("oog_addr", 16'(bus.cell_addr), 16'd0);
    filler(); filler();
    check("oog_rgb", 16'(rgb), 16'h000);

    // Frames 16..31 hide food
    for (int f = 0; f < 16; f++) begin
      px(0, 0, 1'b0, 1'b1, 1'b0);
      px(0, 0, 1'b0, 1'b1, 1'b1);
    end
    px(152, 56, 1'b1, 1'b1, 1'b1);
    filler(); filler();
    check("food_blink16", 16'(rgb), 16'h000);

    // Wrap 31 -> 0 shows food again
    for (int f = 0; f < 16; f++) begin
      px(0, 0, 1'b0, 1'b1, 1'b0);
      px(0, 0, 1'b0, 1'b1, 1'b1);
    end
    px(152, 56, 1'b1, 1'b1, 1'b1);
    filler(); filler();
    check("food_wrap", 16'(rgb), 16'hF0F);

    // pix_ce held high: one pixel per clk
    bus.pix_ce = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (i < 5) drive(sh_h[i], sh_v[i], 1'b1, sh_hs[i], 1'b1);
      else       drive(0, 0, 1'b0, 1'b1, 1'b1);
      @(negedge clk_100mhz);
      $display("stream step %0d -> rgb=%h hsync=%0b", i, rgb, bus.HSYNC);
      if (i >= 2) begin
        check($sformatf("stream_rgb%0d", i - 2), 16'(rgb), 16'(sh_rgb[i - 2]));
        check($sformatf("stream_hs%0d", i - 2), 16'(bus.HSYNC), 16'(sh_hs[i - 2]));
      end
    end
    bus.pix_ce = 1'b0;
    @(negedge clk_100mhz);

    // Reset mid-stream
    px(100, 50, 1'b1, 1'b0, 1'b0);
    px(100, 50, 1'b1, 1'b0, 1'b0);
    px(100, 50, 1'b1, 1'b0, 1'b0);
    check("pre_rst_rgb", 16'(rgb), 16'h0F0);
    check("pre_rst_hs",  16'(bus.HSYNC), 16'h0);
    check("pre_rst_addr", 16'(bus.cell_addr), 16'd126);
    RST = 1'b1;
    #1;
    check("mid_rst_rgb",  16'(rgb), 16'h000);
    check("mid_rst_hs",   16'(bus.HSYNC), 16'h1);
    check("mid_rst_vs",   16'(bus.VSYNC), 16'h1);
    check("mid_rst_addr", 16'(bus.cell_addr), 16'd0);
    @(negedge clk_100mhz);
    RST = 1'b0;
    @(negedge clk_100mhz);
    px(100, 50, 1'b1, 1'b0, 1'b1);
    check("post_rst1_rgb", 16'(rgb), 16'h000);
    px(100, 50, 1'b1, 1'b0, 1'b1);
    check("post_rst2_rgb", 16'(rgb), 16'h000);
    check("post_rst2_hs",  16'(bus.HSYNC), 16'h1);
    px(100, 50, 1'b1, 1'b0, 1'b1);
    check("post_rst3_rgb", 16'(rgb), 16'h0F0);
    check("post_rst3_hs",  16'(bus.HSYNC), 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mism_cnt);
    $finish;
  end
endmodule
